// File: rtl/fft_mdc_commutator_if.sv
// Two-lane sample bus into and out of the MDC commutator: input pair with framing/mode,
// output pair with position, framing-error flag and valid. No backpressure.
interface fft_mdc_commutator_if #(
  parameter int W  = 16,
  parameter int PW = 3
);
  logic                in_en;
  logic                bypass;
  logic signed [W-1:0] x0r, x0i, x1r, x1i;

  logic                out_en;
  logic [PW-1:0]       phase;
  logic                err;
  logic signed [W-1:0] y0r, y0i, y1r, y1i;

  modport master (
    output in_en, bypass, x0r, x0i, x1r, x1i,
    input  out_en, phase, err, y0r, y0i, y1r, y1i
  );

  modport slave (
    input  in_en, bypass, x0r, x0i, x1r, x1i,
    output out_en, phase, err, y0r, y0i, y1r, y1i
  );
endinterface

// File: rtl/fft_mdc_commutator.sv
// Radix-2 MDC delay-switch-delay commutator: pairs samples D apart on a lane; latency D+1 cycles.
// Free-running stream with no backpressure; delay lines shift every cycle.
module fft_mdc_commutator #(
  parameter int W     = 16,
  parameter int N     = 16,
  parameter int STAGE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_mdc_commutator_if.slave  bus
);
  localparam int D  = N >> (STAGE + 2);
  localparam int PW = $clog2(2 * D);
  localparam logic [PW-1:0] LAST = PW'(2 * D - 1);

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  // Per-cycle control carried alongside the data through the D-deep alignment pipe.
  typedef struct packed {
    logic          en;
    logic          mode;
    logic [PW-1:0] pos;
  } tag_t;

  cplx_t         x0, x1;
  cplx_t         lane0_q [D];
  cplx_t         lane1_q [2*D];
  tag_t          tag_q   [D];
  tag_t          tag_in, tag_out;

  logic [PW-1:0] ip_q, ip_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic          out_en_q;
  logic [PW-1:0] phase_q, phase_d;
  cplx_t         y0_q, y1_q, y0_d, y1_d;
  logic          blk_start;

  always_comb begin
    x0        = '{re: bus.x0r, im: bus.x0i};
    x1        = '{re: bus.x1r, im: bus.x1i};
    blk_start = bus.in_en && (ip_q == '0);
    mode_d    = blk_start ? bus.bypass : mode_q;

    if (bus.in_en) ip_d = (ip_q == LAST) ? '0 : ip_q + 1'b1;
    else           ip_d = '0;

    err_d  = err_q | (!bus.in_en && (ip_q != '0));
    tag_in = '{en: bus.in_en, mode: mode_d, pos: ip_q};
  end

  assign tag_out = tag_q[D-1];

  // Pair j is assembled one cycle before it is presented; pos of the tag is j.
  always_comb begin
    y0_d = lane0_q[D-1];
    y1_d = lane1_q[D-1];
    if (!tag_out.mode) begin
      if (tag_out.pos < PW'(D)) begin
        y0_d = lane0_q[D-1];
        y1_d = x0;
      end else begin
        y0_d = lane1_q[2*D-1];
        y1_d = lane1_q[D-1];
      end
    end

    if (tag_out.en)    phase_d = tag_out.pos;
    else if (out_en_q) phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
    else               phase_d = phase_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_q     <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      out_en_q <= 1'b0;
      phase_q  <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      for (int k = 0; k < D; k++) begin
        lane0_q[k] <= '0;
        tag_q[k]   <= '0;
      end
      for (int k = 0; k < 2*D; k++) lane1_q[k] <= '0;
    end else begin
      ip_q     <= ip_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      out_en_q <= tag_out.en;
      phase_q  <= phase_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      lane0_q[0] <= x0;
      tag_q[0]   <= tag_in;
      for (int k = 1; k < D; k++) begin
        lane0_q[k] <= lane0_q[k-1];
        tag_q[k]   <= tag_q[k-1];
      end
      lane1_q[0] <= x1;
      for (int k = 1; k < 2*D; k++) lane1_q[k] <= lane1_q[k-1];
    end
  end

  assign bus.out_en = out_en_q;
  assign bus.phase  = phase_q;
  assign bus.err    = err_q;
  assign bus.y0r    = y0_q.re;
  assign bus.y0i    = y0_q.im;
  assign bus.y1r    = y1_q.re;
  assign bus.y1i    = y1_q.im;
endmodule

// File: doc/fft_mdc_commutator.md
Name: fft_mdc_commutator

Overview:
- Parametrised two-lane MDC commutator (delay-switch-delay) for the radix-2 pipelined FFT.
- Sits between butterfly stages. It regroups the two parallel sample streams so that samples D pairs apart on the same lane leave together as one butterfly pair.
- Generalises the fixed N=8 first-stage reorder to any power-of-two N and stage index. Adds frame phase tracking, a per-frame bypass mode and a framing-error flag.

Parameters:
- W, `W: real/imag sample width, signed two's complement.
- N, 16: FFT size, power of two, >= 8.
- STAGE, 0: commutator index. D = N >> (STAGE+2); legal 0..log2(N)-3 so that D >= 1 (and D >= 2 in practice).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_en  in  1  input pair valid; asserted in contiguous bursts of 2D cycles.
- bypass  in  1  mode select; sampled only on the first cycle of each input block.
- x0r, x0i  in  W each  lane-0 sample (signed).
- x1r, x1i  in  W each  lane-1 sample (signed).
- out_en  out  1  output pair valid.
- phase  out  log2(2D)  output-side position within block, 0..2D-1.
- err  out  1  sticky framing error.
- y0r, y0i, y1r, y1i  out  W each  output pair (signed).

Behaviour:
- Block definition: 2D consecutive valid cycles, counted by input phase counter ip (0..2D-1, increments on in_en, wraps 2D-1->0). Lane 0 carries A[0..2D-1], lane 1 carries B[0..2D-1]; block starts when in_en=1 and ip=0.
- Normal mode, output pair j of a block (j=0..2D-1):
  - j < D: (y0,y1) = (A[j], A[j+D]).
  - j >= D: (y0,y1) = (B[j-D], B[j]).
- Bypass mode: (y0,y1) = (A[j], B[j]).
- Latency is fixed at D+1 cycles in both modes. Pair j appears at block-start cycle + D+1+j. out_en = in_en delayed exactly D+1 cycles.
- phase: counts on out_en and wraps like ip; it equals j while out_en=1.
- Back-to-back blocks: streaming with no bubbles. Delay lines shift every cycle regardless of in_en. Lane-1 storage depth is 2D+1, lane-0 depth is D+1.
- bypass timing: latched into a mode register at block start and carried with the block through the D+1 pipeline. Changes mid-block take effect at the next block only. Adjacent blocks in different modes must both output correctly.
- Framing error: err is set when in_en falls while ip != 0.
  - In that case ip resets to 0, and the next in_en starts a new block.
  - Outputs for the truncated block are don't-care, but out_en still tracks in_en delayed by D+1.
  - err clears only on reset.
- Reset, asynchronous, all registers including delay lines: out_en=0, phase=0, err=0, y*=0, ip=0, mode=0, delay-line shift register cleared. Reset mid-block discards the block; first valid input after release starts block 0.
- Data path is pure routing: no arithmetic, no width change, sign preserved bit-exact.
- When out_en=0, y* carry delay-line contents. They are not held at zero and must not be checked.

Test Plan:
- N=16, STAGE=0 (D=4), bypass=0, one block starting cycle 0 with x0r=t, x1r=100+t, imag=-(real) -> out_en high cycles 5..12. y0r/y1r = (0,4),(1,5),(2,6),(3,7),(100,104),(101,105),(102,106),(103,107); imag equals negated real; phase 0..7.
- Same stimulus, three back-to-back blocks (24 cycles, values offset +8 per block) -> 24 contiguous valid output cycles; block k outputs the same pattern shifted by 8k in value; no bubble; phase wraps 7->0.
- bypass=1 for block 0 and 0 for block 1, toggled mid-block 1 -> block 0 outputs (t,100+t) at cycles 5..12; block 1 outputs the swapped normal pattern; the mid-block toggle has no effect.
- in_en drops after 3 cycles of a block -> err=1 from the next cycle onward. A following clean block still outputs the correct pattern after D+1 cycles, and err stays 1.
- N=8, STAGE=0 (D=2) with values 0x8000 / 0x7FFF on lanes -> latency 3; pairs (A0,A2),(A1,A3),(B0,B2),(B1,B3); extreme values pass bit-exact.
- Assert rst_n low mid-block -> all outputs 0 immediately (asynchronous); after release a full block produces a correct output D+1 cycles later with no stale data while out_en=1.
